// File: rtl/load_store_unit_if.sv
// Bundle of execute-request, dataMemory and writeback signals used by the
// memory-access stage. The slave view is the load/store unit itself; the master
// view is its surroundings (execute, dataMemory and writeback).
interface load_store_unit_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int RD_W   = 3
) ();
    // Request from execute
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [RD_W-1:0]   req_rd;

    // dataMemory port
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    // Response to writeback
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [RD_W-1:0]   wb_rd;

    // Out-of-range access pulse
    logic              err;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_rd,
        input  mem_rdata, wb_ready,
        output req_ready, mem_addr, mem_wdata, mem_write,
        output wb_valid, wb_data, wb_rd, err
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_rd,
        output mem_rdata, wb_ready,
        input  req_ready, mem_addr, mem_wdata, mem_write,
        input  wb_valid, wb_data, wb_rd, err
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access pipeline stage sitting in front of dataMemory.
// Takes one load/store at a time from execute, drives the memory port for one
// ACCESS cycle, waits READ_LAT cycles for load data and hands the result to
// writeback with a valid/ready handshake. Out-of-range addresses raise a
// one-cycle err pulse, never write memory, and loads from them return zero.
module load_store_unit #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int RD_W      = 3,
    parameter int READ_LAT  = 1,
    parameter int MEM_DEPTH = 256
) (
    input  logic                  sysclk,
    input  logic                  rst_n,
    load_store_unit_if.slave      bus
);

    // One extra bit so that a depth of 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [2:0]      LAT_L   = 3'(READ_LAT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_q;
    logic                write_q;
    logic                inrange_q;
    logic [RD_W-1:0]     rd_q;
    logic [2:0]          cnt_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                mem_write_q;
    logic                wb_valid_q;
    logic [DATA_W-1:0]   wb_data_q;
    logic [RD_W-1:0]     wb_rd_q;
    logic                err_q;
    logic                in_range_s;

    // Range check is done on the incoming address so err can be registered
    // straight into the ACCESS cycle.
    assign in_range_s = ({1'b0, bus.req_addr} < DEPTH_L);

    // Ready is gated by rst_n so execute never sees a handshake during reset.
    assign bus.req_ready = (state_q == IDLE) & rst_n;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_write = mem_write_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.err       = err_q;

    // Request sequencing FSM with all memory/writeback outputs registered.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            inrange_q   <= 1'b0;
            rd_q        <= {RD_W{1'b0}};
            cnt_q       <= 3'd0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            mem_write_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= {DATA_W{1'b0}};
            wb_rd_q     <= {RD_W{1'b0}};
            err_q       <= 1'b0;
        end else begin
            // Write strobe and error are single-cycle pulses by construction.
            mem_write_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_q     <= bus.req_write;
                        inrange_q   <= in_range_s;
                        rd_q        <= bus.req_rd;
                        mem_addr_q  <= bus.req_addr;
                        mem_wdata_q <= bus.req_wdata;
                        mem_write_q <= bus.req_write & in_range_s;
                        err_q       <= ~in_range_s;
                        state_q     <= ACCESS;
                    end else begin
                        state_q     <= IDLE;
                    end
                end
                ACCESS: begin
                    if (write_q) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= LAT_L;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 3'd1) begin
                        wb_data_q  <= inrange_q ? bus.mem_rdata : {DATA_W{1'b0}};
                        wb_rd_q    <= rd_q;
                        wb_valid_q <= 1'b1;
                        cnt_q      <= 3'd0;
                        state_q    <= RESP;
                    end else begin
                        cnt_q      <= cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    // No timeout: a stalled writeback holds the result here.
                    if (bus.wb_ready) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        wb_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (READ_LAT=1, MEM_DEPTH=16) with a
// one-cycle synchronous dataMemory model behind it.
module tb_load_store_unit;

    logic sysclk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [7:0] mem [0:255];
    logic [7:0] rdata_r;

    load_store_unit_if #(.DATA_W(8), .ADDR_W(8), .RD_W(3)) bus ();

    load_store_unit #(
        .DATA_W(8), .ADDR_W(8), .RD_W(3), .READ_LAT(1), .MEM_DEPTH(16)
    ) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    // 100 MHz-style free-running clock
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // dataMemory model: synchronous write, one-cycle registered read
    always @(posedge sysclk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
        rdata_r <= mem[bus.mem_addr];
    end
    assign bus.mem_rdata = rdata_r;

    // Background fill so masked out-of-range data is distinguishable from zero
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hAA;
        rdata_r = 8'h00;
    end

    // Absolute backstop against a hang
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic do_store(input logic [7:0] a, input logic [7:0] d,
                            output logic wr_seen, output logic err_seen);
        bus.req_valid = 1'b1; bus.req_write = 1'b1;
        bus.req_addr  = a;    bus.req_wdata = d; bus.req_rd = 3'd0;
        @(negedge sysclk);
        wr_seen = bus.mem_write;
        err_seen = bus.err;
        bus.req_valid = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic do_load(input logic [7:0] a, input logic [2:0] rd,
                           output logic [7:0] d, output logic [2:0] r, output int lat,
                           output logic wr_seen, output logic err_seen);
        lat = 99; d = 8'h00; r = 3'd0;
        bus.req_valid = 1'b1; bus.req_write = 1'b0;
        bus.req_addr  = a;    bus.req_wdata = 8'h00; bus.req_rd = rd;
        @(negedge sysclk);
        bus.req_valid = 1'b0;
        wr_seen = bus.mem_write;
        err_seen = bus.err;
        for (int i = 1; i <= 20; i++) begin
            @(negedge sysclk);
            wr_seen = wr_seen | bus.mem_write;
            err_seen = err_seen | bus.err;
            if (bus.wb_valid) begin
                lat = i; d = bus.wb_data; r = bus.wb_rd;
                break;
            end
        end
        @(negedge sysclk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge sysclk);
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", bus.req_ready); end
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", bus.wb_valid); end
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b exp 0", bus.mem_write); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
        checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr got %h exp 00", bus.mem_addr); end
        checks++; if (bus.wb_data !== 8'h00 || bus.wb_rd !== 3'd0) begin errors++; $display("FAIL reset_wb got %h/%0d exp 00/0", bus.wb_data, bus.wb_rd); end
        rst_n = 1'b1;
        @(negedge sysclk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", bus.req_ready); end
    endtask

    task automatic test_store_load();
        logic w, e;
        logic [7:0] d;
        logic [2:0] r;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_store(8'(i), 8'(i + 1), w, e);
            checks++; if (w !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL store%0d_strobe got wr=%b err=%b exp wr=1 err=0", i, w, e); end
            checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL store%0d_ready got %b exp 1", i, bus.req_ready); end
        end
        for (int i = 0; i < 4; i++) begin
            do_load(8'(i), 3'(i + 4), d, r, lat, w, e);
            checks++; if (d !== 8'(i + 1)) begin errors++; $display("FAIL load%0d_data got %h exp %h", i, d, 8'(i + 1)); end
            checks++; if (r !== 3'(i + 4)) begin errors++; $display("FAIL load%0d_rd got %0d exp %0d", i, r, i + 4); end
        end
    endtask

    task automatic test_load_latency();
        logic w, e;
        logic [7:0] d;
        logic [2:0] r;
        int lat;
        do_load(8'h02, 3'd5, d, r, lat, w, e);
        // wb_valid first high in cycle k+3, i.e. two sample points after k+1
        checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency got %0d exp 2", lat); end
        checks++; if (w !== 1'b0) begin errors++; $display("FAIL load_mem_write got %b exp 0", w); end
        checks++; if (d !== 8'h03) begin errors++; $display("FAIL load_latency_data got %h exp 03", d); end
    endtask

    task automatic test_backpressure();
        logic w, e;
        logic [7:0] d;
        logic [2:0] r;
        int lat;
        bus.wb_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'h03; bus.req_rd = 3'd1;
        @(negedge sysclk);
        bus.req_valid = 1'b0;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge sysclk);
            if (bus.wb_valid) begin lat = i; break; end
        end
        checks++; if (lat !== 2) begin errors++; $display("FAIL stall_latency got %0d exp 2", lat); end
        // A competing store during RESP must be ignored
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 8'h00; bus.req_wdata = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge sysclk);
            checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 8'h04 || bus.wb_rd !== 3'd1) begin errors++; $display("FAIL stall%0d_hold got v=%b d=%h rd=%0d exp v=1 d=04 rd=1", i, bus.wb_valid, bus.wb_data, bus.wb_rd); end
            checks++; if (bus.req_ready !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL stall%0d_busy got ready=%b wr=%b exp 0/0", i, bus.req_ready, bus.mem_write); end
        end
        bus.wb_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL release_same_cycle_ready got %b exp 0", bus.req_ready); end
        @(negedge sysclk);
        bus.req_valid = 1'b0;
        checks++; if (bus.wb_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL release_next_cycle got v=%b ready=%b exp 0/1", bus.wb_valid, bus.req_ready); end
        do_load(8'h00, 3'd2, d, r, lat, w, e);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL ignored_store_data got %h exp 01", d); end
    endtask

    task automatic test_out_of_range();
        logic w, e;
        logic [7:0] d;
        logic [2:0] r;
        int lat;
        do_store(8'h20, 8'h77, w, e);
        checks++; if (w !== 1'b0 || e !== 1'b1) begin errors++; $display("FAIL oor_store got wr=%b err=%b exp wr=0 err=1", w, e); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse got %b exp 0", bus.err); end
        checks++; if (mem[8'h20] !== 8'hAA) begin errors++; $display("FAIL oor_mem_untouched got %h exp AA", mem[8'h20]); end
        do_load(8'h20, 3'd6, d, r, lat, w, e);
        checks++; if (d !== 8'h00 || r !== 3'd6) begin errors++; $display("FAIL oor_load got %h/%0d exp 00/6", d, r); end
        checks++; if (lat !== 2 || e !== 1'b1) begin errors++; $display("FAIL oor_load_timing got lat=%0d err=%b exp 2/1", lat, e); end
        // Highest in-range word
        do_store(8'h0F, 8'h3C, w, e);
        checks++; if (w !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL edge_store got wr=%b err=%b exp 1/0", w, e); end
        do_load(8'h0F, 3'd7, d, r, lat, w, e);
        checks++; if (d !== 8'h3C || e !== 1'b0) begin errors++; $display("FAIL edge_load got %h err=%b exp 3C/0", d, e); end
        // First out-of-range word
        do_store(8'h10, 8'h11, w, e);
        checks++; if (w !== 1'b0 || e !== 1'b1) begin errors++; $display("FAIL first_oor_store got wr=%b err=%b exp 0/1", w, e); end
    endtask

    task automatic test_reset_in_wait();
        logic w, e;
        logic [7:0] d;
        logic [2:0] r;
        int lat;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'h01; bus.req_rd = 3'd3;
        @(negedge sysclk);
        bus.req_valid = 1'b0;
        @(negedge sysclk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.wb_valid !== 1'b0 || bus.mem_write !== 1'b0 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_in_wait got v=%b wr=%b ready=%b exp 0/0/0", bus.wb_valid, bus.mem_write, bus.req_ready); end
        @(negedge sysclk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sysclk);
            checks++; if (bus.wb_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_no_stale%0d got v=%b ready=%b exp 0/1", i, bus.wb_valid, bus.req_ready); end
        end
        do_load(8'h01, 3'd3, d, r, lat, w, e);
        checks++; if (d !== 8'h02 || r !== 3'd3 || lat !== 2) begin errors++; $display("FAIL rst_recover got %h/%0d lat %0d exp 02/3 lat 2", d, r, lat); end
    endtask

    task automatic test_back_to_back();
        logic w, e;
        logic [7:0] d;
        logic [2:0] r;
        int lat;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 8'h05; bus.req_wdata = 8'hA5;
        @(negedge sysclk);
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 8'h05 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_first got wr=%b a=%h ready=%b exp 1/05/0", bus.mem_write, bus.mem_addr, bus.req_ready); end
        @(negedge sysclk);
        checks++; if (bus.mem_write !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap got wr=%b ready=%b exp 0/1", bus.mem_write, bus.req_ready); end
        bus.req_addr = 8'h06; bus.req_wdata = 8'h5A;
        @(negedge sysclk);
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 8'h06 || bus.mem_wdata !== 8'h5A) begin errors++; $display("FAIL b2b_second got wr=%b a=%h d=%h exp 1/06/5A", bus.mem_write, bus.mem_addr, bus.mem_wdata); end
        bus.req_valid = 1'b0;
        @(negedge sysclk);
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL b2b_end got wr=%b exp 0", bus.mem_write); end
        do_load(8'h05, 3'd0, d, r, lat, w, e);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL b2b_load5 got %h exp A5", d); end
        do_load(8'h06, 3'd1, d, r, lat, w, e);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL b2b_load6 got %h exp 5A", d); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 8'h00;
        bus.req_wdata = 8'h00; bus.req_rd = 3'd0; bus.wb_ready = 1'b1;
        test_reset();
        test_store_load();
        test_load_latency();
        test_backpressure();
        test_out_of_range();
        test_reset_in_wait();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
